// File: rtl/biu_constants_pkg.sv
// Bus-interface constants shared across the memory path.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

endpackage

// File: rtl/riscv_mmu_arb_pkg.sv
// Helpers for the MMU request arbiter.
package riscv_mmu_arb_pkg;

  // Physical address width that pairs with a given virtual address width.
  function automatic int plen_for(input int xlen);
    return (xlen == 32) ? 34 : 56;
  endfunction

endpackage

// File: rtl/riscv_mmu_arb_rr.sv
// Combinational two-way round-robin picker; a tie goes to the requester that did not win last.
module riscv_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = ~i_last;
      default: o_winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_mmu_arb.sv
// Two-requester round-robin arbiter in front of the shared translation/memory port.
// Handshake: req_i[i] and its attributes stay stable until ack_o[i]; req_o holds until ack_i.
module riscv_mmu_arb
  import riscv_mmu_arb_pkg::*;
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PLEN = plen_for(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [1:0]      req_i,
  input  logic [XLEN-1:0] adr0_i,
  input  logic [XLEN-1:0] adr1_i,
  input  biu_size_t       size0_i,
  input  biu_size_t       size1_i,
  input  logic            lock0_i,
  input  logic            lock1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  output logic [1:0]      ack_o,
  output logic            req_o,
  output logic [PLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output logic            we_o,
  input  logic            ack_i,
  output logic            gnt_o,
  output logic            busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]      r_state;
  logic            r_req;
  logic [PLEN-1:0] r_adr;
  biu_size_t       r_size;
  logic            r_lock;
  logic            r_we;
  logic            r_gnt;
  logic            r_last;

  logic            w_winner;
  logic            w_valid;
  logic [PLEN-1:0] w_adr0;
  logic [PLEN-1:0] w_adr1;
  logic [1:0]      w_next_state;
  logic            w_issue;
  logic            w_issue_idx;
  logic            w_update_last;
  logic            w_req_gnt;
  logic            w_lock_gnt;

  riscv_rr_arb2 u_rr (
    .i_req    (req_i),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  generate
    if (XLEN == 32) begin : g_zext
      assign w_adr0 = {{(PLEN-XLEN){1'b0}}, adr0_i};
      assign w_adr1 = {{(PLEN-XLEN){1'b0}}, adr1_i};
    end else begin : g_trunc
      assign w_adr0 = adr0_i[PLEN-1:0];
      assign w_adr1 = adr1_i[PLEN-1:0];
    end
  endgenerate

  assign w_req_gnt  = r_gnt ? req_i[1] : req_i[0];
  assign w_lock_gnt = r_gnt ? lock1_i : lock0_i;

  // BUSY ignores flush so an issued transaction always runs to its ack.
  always_comb begin
    w_next_state  = r_state;
    w_issue       = 1'b0;
    w_issue_idx   = r_gnt;
    w_update_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!flush_i && w_valid) begin
          w_issue       = 1'b1;
          w_issue_idx   = w_winner;
          w_update_last = 1'b1;
          w_next_state  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ack_i) w_next_state = r_lock ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: begin
        if (flush_i) begin
          w_next_state = ST_IDLE;
        end else if (w_req_gnt) begin
          w_issue      = 1'b1;
          w_next_state = ST_BUSY;
        end else if (!w_lock_gnt) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_adr   <= '0;
      r_size  <= BYTE;
      r_lock  <= 1'b0;
      r_we    <= 1'b0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_issue) begin
        r_req  <= 1'b1;
        r_gnt  <= w_issue_idx;
        r_adr  <= w_issue_idx ? w_adr1  : w_adr0;
        r_size <= w_issue_idx ? size1_i : size0_i;
        r_lock <= w_issue_idx ? lock1_i : lock0_i;
        r_we   <= w_issue_idx ? we1_i   : we0_i;
      end else if (r_state == ST_BUSY && ack_i) begin
        r_req <= 1'b0;
      end
      if (w_update_last) r_last <= w_winner;
    end
  end

  assign ack_o  = (r_state == ST_BUSY && ack_i) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign req_o  = r_req;
  assign adr_o  = r_adr;
  assign size_o = r_size;
  assign lock_o = r_lock;
  assign we_o   = r_we;
  assign gnt_o  = r_gnt;
  assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_riscv_mmu_arb.sv
// Bench for riscv_mmu_arb: directed scenarios plus randomized traffic against a grant-order model.
module tb_riscv_mmu_arb;
  import biu_constants_pkg::*;

  localparam int XLEN = 32;
  localparam int PLEN = 34;
  localparam int W    = 40;  // {idx, adr[33:0], size[2:0], we, lock}

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [1:0]      req;
  logic [XLEN-1:0] adr0, adr1;
  biu_size_t       size0, size1;
  logic            lock0, lock1, we0, we1;
  logic            ack_in;
  logic [1:0]      ack_o;
  logic            req_o;
  logic [PLEN-1:0] adr_o;
  biu_size_t       size_o;
  logic            lock_o, we_o, gnt_o, busy_o;

  int checks   = 0;
  int failures = 0;
  bit model_last;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] sent_q0[$];
  logic [W-1:0] sent_q1[$];
  logic [1:0]   obs_ack_q[$];

  riscv_mmu_arb #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .req_i   (req),
    .adr0_i  (adr0),
    .adr1_i  (adr1),
    .size0_i (size0),
    .size1_i (size1),
    .lock0_i (lock0),
    .lock1_i (lock1),
    .we0_i   (we0),
    .we1_i   (we1),
    .ack_o   (ack_o),
    .req_o   (req_o),
    .adr_o   (adr_o),
    .size_o  (size_o),
    .lock_o  (lock_o),
    .we_o    (we_o),
    .ack_i   (ack_in),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic present(input int i);
    logic [XLEN-1:0] a;
    biu_size_t       s;
    logic            w;
    a = $urandom;
    s = biu_size_t'($urandom_range(0, 3));
    w = 1'($urandom_range(0, 1));
    if (i == 0) begin
      adr0 = a; size0 = s; we0 = w; lock0 = 1'b0; req[0] = 1'b1;
      sent_q0.push_back({1'b0, 2'b00, a, s, w, 1'b0});
    end else begin
      adr1 = a; size1 = s; we1 = w; lock1 = 1'b0; req[1] = 1'b1;
      sent_q1.push_back({1'b1, 2'b00, a, s, w, 1'b0});
    end
  endtask

  // Both requesters keep requesting while they have work; a downstream
  // responder acks each issued request after dmin..dmax extra cycles.
  task automatic drive_traffic(input int n0, input int n1, input int dmin, input int dmax,
                               output bit to);
    int rem[2];
    bit drop[2];
    bit rearm[2];
    bit inflight;
    int dly;
    int cyc;
    rem[0] = n0; rem[1] = n1;
    drop[0] = 0; drop[1] = 0; rearm[0] = 0; rearm[1] = 0;
    inflight = 0; dly = 0; cyc = 0;
    sent_q0.delete(); sent_q1.delete();
    obs_q.delete(); obs_ack_q.delete();
    if (n0 > 0) present(0);
    if (n1 > 0) present(1);
    while ((rem[0] + rem[1] > 0 || inflight) && cyc < 3000) begin
      tick();
      cyc++;
      ack_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin
          req[i] = 1'b0; drop[i] = 0; rearm[i] = (rem[i] > 0);
        end else if (rearm[i]) begin
          present(i); rearm[i] = 0;
        end
      end
      if (!inflight && req_o) begin
        inflight = 1;
        dly = $urandom_range(dmin, dmax);
        obs_q.push_back({gnt_o, adr_o, size_o, we_o, lock_o});
      end
      if (inflight) begin
        if (dly == 0) begin
          ack_in = 1'b1;
          #1;
          obs_ack_q.push_back(ack_o);
          for (int i = 0; i < 2; i++)
            if (ack_o[i] && rem[i] > 0) begin drop[i] = 1; rem[i]--; end
          inflight = 0;
        end else begin
          dly--;
        end
      end
    end
    to = (rem[0] + rem[1] > 0) || inflight;
    tick();
    ack_in = 1'b0;
    for (int i = 0; i < 2; i++) if (drop[i]) req[i] = 1'b0;
  endtask

  // reference model: the order in which pending transactions are granted
  task automatic build_expected();
    exp_q.delete();
    while (sent_q0.size() > 0 || sent_q1.size() > 0) begin
      automatic bit pick;
      if (sent_q0.size() > 0 && sent_q1.size() > 0) pick = !model_last;
      else pick = (sent_q0.size() == 0);
      if (pick) exp_q.push_back(sent_q1.pop_front());
      else      exp_q.push_back(sent_q0.pop_front());
      model_last = pick;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req = 2'b00; ack_in = 1'b1;
    adr0 = '0; adr1 = '0; size0 = BYTE; size1 = BYTE;
    lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (3) tick();
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req_o); end
    checks++; if (adr_o !== '0) begin failures++; $display("FAIL reset_adr got=%h exp=0", adr_o); end
    checks++; if (size_o !== BYTE) begin failures++; $display("FAIL reset_size got=%h exp=0", size_o); end
    checks++; if ({lock_o, we_o, gnt_o, busy_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {lock_o, we_o, gnt_o, busy_o}); end
    checks++; if (ack_o !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack_o); end
    ack_in = 1'b0;
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_tie();
    bit to;
    drive_traffic(2, 2, 1, 1, to);
    build_expected();
    checks++; if (to) begin failures++; $display("FAIL tie_timeout got=1 exp=0"); end
    checks++; if (obs_q.size() !== 4 || obs_ack_q.size() !== 4) begin
      failures++; $display("FAIL tie_count got=%0d/%0d exp=4", obs_q.size(), obs_ack_q.size()); end
    for (int k = 0; k < obs_q.size() && k < obs_ack_q.size() && k < exp_q.size(); k++) begin
      checks++; if (obs_q[k][W-1] !== k[0]) begin
        failures++; $display("FAIL tie_order[%0d] got=%b exp=%b", k, obs_q[k][W-1], k[0]); end
      checks++; if (obs_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL tie_txn[%0d] got=%h exp=%h", k, obs_q[k], exp_q[k]); end
      checks++; if (obs_ack_q[k] !== (k[0] ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL tie_ack[%0d] got=%b exp=%b", k, obs_ack_q[k], k[0] ? 2'b10 : 2'b01); end
    end
  endtask

  task automatic test_single();
    req = 2'b01; adr0 = 32'h0000_1000; we0 = 1'b1; size0 = WORD; lock0 = 1'b0;
    tick();
    checks++; if (req_o !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", req_o); end
    checks++; if (adr_o !== 34'h0_0000_1000) begin failures++; $display("FAIL single_adr got=%h exp=000001000", adr_o); end
    checks++; if ({we_o, gnt_o, busy_o} !== 3'b101) begin
      failures++; $display("FAIL single_we_gnt_busy got=%b exp=101", {we_o, gnt_o, busy_o}); end
    checks++; if (size_o !== WORD) begin failures++; $display("FAIL single_size got=%h exp=%h", size_o, WORD); end
    tick();
    checks++; if (req_o !== 1'b1 || ack_o !== 2'b00) begin
      failures++; $display("FAIL single_hold got=%b/%b exp=1/00", req_o, ack_o); end
    tick();
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", ack_o); end
    tick();
    ack_in = 1'b0; req = 2'b00; we0 = 1'b0;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL single_done got=%b/%b exp=0/0", req_o, busy_o); end
    tick();
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", req_o); end
    model_last = 1'b0;
  endtask

  task automatic test_locked();
    logic [XLEN-1:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    req = 2'b10; adr1 = a; lock1 = 1'b1; we1 = 1'b1; size1 = WORD;
    tick();
    checks++; if ({req_o, gnt_o, lock_o} !== 3'b111 || adr_o !== {2'b00, a}) begin
      failures++; $display("FAIL lock_first got=%b adr=%h exp=111 adr=%h", {req_o, gnt_o, lock_o}, adr_o, {2'b00, a}); end
    req[0] = 1'b1; adr0 = b; lock0 = 1'b0; we0 = 1'b0; size0 = BYTE;
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b10) begin failures++; $display("FAIL lock_ack1 got=%b exp=10", ack_o); end
    tick();
    ack_in = 1'b0; req[1] = 1'b0;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL lock_hold got=%b/%b exp=0/1", req_o, busy_o); end
    tick();
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL lock_block0 got=%b exp=0", req_o); end
    req[1] = 1'b1; lock1 = 1'b0; adr1 = c;
    tick();
    checks++; if ({req_o, gnt_o, lock_o} !== 3'b110 || adr_o !== {2'b00, c}) begin
      failures++; $display("FAIL lock_second got=%b adr=%h exp=110 adr=%h", {req_o, gnt_o, lock_o}, adr_o, {2'b00, c}); end
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b10) begin failures++; $display("FAIL lock_ack2 got=%b exp=10", ack_o); end
    tick();
    ack_in = 1'b0; req[1] = 1'b0;
    tick();
    checks++; if ({req_o, gnt_o} !== 2'b10 || adr_o !== {2'b00, b}) begin
      failures++; $display("FAIL lock_then0 got=%b adr=%h exp=10 adr=%h", {req_o, gnt_o}, adr_o, {2'b00, b}); end
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b01) begin failures++; $display("FAIL lock_ack0 got=%b exp=01", ack_o); end
    tick();
    ack_in = 1'b0; req[0] = 1'b0;
    tick();
    model_last = 1'b0;
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] a;
    a = $urandom;
    flush = 1'b1; req = 2'b10; adr1 = a; lock1 = 1'b0; we1 = 1'b0; size1 = HWORD;
    tick();
    flush = 1'b0;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle got=%b/%b exp=0/0", req_o, busy_o); end
    tick();
    checks++; if ({req_o, gnt_o} !== 2'b11 || adr_o !== {2'b00, a}) begin
      failures++; $display("FAIL flush_issue got=%b adr=%h exp=11 adr=%h", {req_o, gnt_o}, adr_o, {2'b00, a}); end
    flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (req_o !== 1'b1 || adr_o !== {2'b00, a} || busy_o !== 1'b1) begin
        failures++; $display("FAIL flush_busy[%0d] got=%b adr=%h exp=1 adr=%h", k, req_o, adr_o, {2'b00, a}); end
    end
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b10) begin failures++; $display("FAIL flush_ack got=%b exp=10", ack_o); end
    tick();
    flush = 1'b0; ack_in = 1'b0; req = 2'b00;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_done got=%b/%b exp=0/0", req_o, busy_o); end
    tick();
    model_last = 1'b1;
  endtask

  task automatic test_abandon();
    logic [XLEN-1:0] a, b;
    a = $urandom; b = $urandom;
    req = 2'b01; adr0 = a; lock0 = 1'b1; we0 = 1'b0; size0 = BYTE;
    tick();
    checks++; if ({req_o, gnt_o, lock_o} !== 3'b101) begin
      failures++; $display("FAIL abandon_first got=%b exp=101", {req_o, gnt_o, lock_o}); end
    req[1] = 1'b1; adr1 = b; lock1 = 1'b0; we1 = 1'b1; size1 = DWORD;
    ack_in = 1'b1; #1;
    checks++; if (ack_o !== 2'b01) begin failures++; $display("FAIL abandon_ack got=%b exp=01", ack_o); end
    tick();
    ack_in = 1'b0; req[0] = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b1 || req_o !== 1'b0) begin
      failures++; $display("FAIL abandon_locked got=%b/%b exp=1/0", busy_o, req_o); end
    lock0 = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin
      failures++; $display("FAIL abandon_idle got=%b/%b exp=0/0", busy_o, req_o); end
    tick();
    checks++; if ({req_o, gnt_o, we_o} !== 3'b111 || adr_o !== {2'b00, b} || size_o !== DWORD) begin
      failures++; $display("FAIL abandon_other got=%b adr=%h exp=111 adr=%h", {req_o, gnt_o, we_o}, adr_o, {2'b00, b}); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0; req = 2'b00;
    tick();
    model_last = 1'b1;
  endtask

  task automatic test_random();
    bit to;
    for (int r = 0; r < 6; r++) begin
      drive_traffic($urandom_range(1, 5), $urandom_range(0, 5), 0, 3, to);
      build_expected();
      checks++; if (to || obs_q.size() !== exp_q.size() || obs_ack_q.size() !== exp_q.size()) begin
        failures++; $display("FAIL rand_count[%0d] got=%0d/%0d exp=%0d timeout=%b", r, obs_q.size(), obs_ack_q.size(), exp_q.size(), to); end
      for (int k = 0; k < obs_q.size() && k < obs_ack_q.size() && k < exp_q.size(); k++) begin
        checks++; if (obs_q[k] !== exp_q[k]) begin
          failures++; $display("FAIL rand_txn[%0d.%0d] got=%h exp=%h", r, k, obs_q[k], exp_q[k]); end
        checks++; if (obs_ack_q[k] !== (exp_q[k][W-1] ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL rand_ack[%0d.%0d] got=%b exp=%b", r, k, obs_ack_q[k], exp_q[k][W-1] ? 2'b10 : 2'b01); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    req = 2'b01; adr0 = $urandom; lock0 = 1'b0;
    tick();
    checks++; if (req_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", req_o); end
    #2;
    rst_n = 1'b0; ack_in = 1'b1;
    #1;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0 || ack_o !== 2'b00 || adr_o !== '0) begin
      failures++; $display("FAIL rstmid_async got=%b/%b/%b adr=%h exp=0/0/00 adr=0", req_o, busy_o, ack_o, adr_o); end
    ack_in = 1'b0; req = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
    drive_traffic(1, 1, 0, 2, to);
    build_expected();
    checks++; if (to || obs_q.size() !== 2) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=2 timeout=%b", obs_q.size(), to); end
    checks++; if (obs_q.size() > 0 && obs_q[0][W-1] !== 1'b0) begin
      failures++; $display("FAIL rstmid_first got=%b exp=0", obs_q[0][W-1]); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL rstmid_txn[%0d] got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_locked();
    test_flush();
    test_abandon();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
